mux4_1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 16-bit 4:1 mux datapath. Four requesters each present a data word with a request/last pair. The block grants one requester at a time, drives the 2-bit mux selector, and forwards the selected word downstream over a valid/ready handshake. Bursts are bounded so no requester can hold the mux indefinitely.

---
 rtl/mux4_1_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux4_1_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_1_arbiter.sv
// ============================================================================
// Module   : mux4_1_arbiter
// Brief    : Round-robin arbiter/sequencer for a 4:1 mux with bounded bursts
//            and a valid/ready downstream handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_1_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [8:0] c_max_burst = 9'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_sel,   w_sel_nxt;
    logic [1:0] r_ptr,   w_ptr_nxt;
    logic [3:0] r_gnt,   w_gnt_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;

    logic       w_req_sel;
    logic       w_last_sel;
    logic       w_valid;
    logic       w_accept;
    logic [7:0] w_cnt_inc;
    logic       w_burst_done;
    logic       w_found;
    logic [1:0] w_winner;

    assign w_req_sel    = req[r_sel];
    assign w_last_sel   = last[r_sel];
    assign w_valid      = (r_state == ST_GRANT) && w_req_sel;
    assign w_accept     = w_valid && out_ready;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_burst_done = ({1'b0, w_cnt_inc} >= c_max_burst);

    // Rotating priority: first set request at or after the pointer, mod 4.
    always_comb begin : p_pick
        logic [1:0] w_idx;
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_winner;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_GRANT: begin
                // A withdrawn request releases without transferring a beat.
                if (!w_req_sel) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_sel + 2'd1;
                end else if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_last_sel || w_burst_done) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_ptr_nxt   = r_sel + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    out_data = data0;
            2'd1:    out_data = data1;
            2'd2:    out_data = data2;
            default: out_data = data3;
        endcase
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_valid = w_valid;
    assign busy      = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_mux4_1_arbiter.sv
// ============================================================================
// Module   : tb_mux4_1_arbiter
// Brief    : Randomised and directed bench for mux4_1_arbiter against a
//            behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_1_arbiter;

    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] data0, data1, data2, data3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int n_cmp;
    int n_err;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;

    mux4_1_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_data(input int idx);
        case (idx)
            0:       return data0;
            1:       return data1;
            2:       return data2;
            default: return data3;
        endcase
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Model the effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (req[idx]) begin
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 4;
        end else if (out_ready) begin
            m_cnt++;
            if (last[m_owner] || m_cnt == MAX_BURST) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
            end
        end
    endtask

    task automatic check_outputs();
        check("gnt",       32'(gnt),       m_busy ? 32'(4'b0001 << m_owner) : 32'd0);
        check("sel",       32'(sel),       32'(m_owner));
        check("busy",      32'(busy),      32'(m_busy));
        check("out_valid", 32'(out_valid), 32'(m_busy && req[m_owner]));
        check("out_data",  32'(out_data),  32'(pick_data(m_owner)));
    endtask

    // One cycle: apply inputs just after the edge, check mid-cycle, then
    // advance the model over the coming edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        @(posedge clk);
        #1;
        req       = r;
        last      = l;
        out_ready = rdy;
        data0     = WIDTH'($urandom);
        data1     = WIDTH'($urandom);
        data2     = WIDTH'($urandom);
        data3     = WIDTH'($urandom);
        #2;
        check_outputs();
        model_edge();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #2;
        req   = 4'b1111;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        req = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        out_ready = 1'b0;
        data0     = 16'h0000;
        data1     = 16'h1111;
        data2     = 16'h2222;
        data3     = 16'h3333;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_outputs();
        rst_n = 1'b1;

        // Single requester, three beats, last on the third
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Fairness with one-beat bursts
        repeat (12) step(4'b1111, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Forced rotation: requester 2 never ends its burst
        repeat (24) step(4'b1100, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Backpressure on requester 1
        step(4'b0010, 4'b0000, 1'b1);
        repeat (5) step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0010, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Withdrawal and pointer wrap
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b1001, 4'b0000, 1'b1);
        step(4'b1001, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Reset mid-burst, then a fresh grant to requester 1
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        async_reset();
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0010, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            logic [3:0] l;
            for (int b = 0; b < 4; b++) begin
                r[b] = ($urandom_range(0, 9) < 8);
                l[b] = ($urandom_range(0, 9) < 2);
            end
            if ($urandom_range(0, 299) == 0)
                async_reset();
            else
                step(r, l, 1'($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
